// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Optional perf counters are enabled with the HAZARD_PERF_EN macro (see hazard_controller).
package hazard_pkg;

    // Redirect-holding FSM: IDLE is normal operation, REDIR_PEND holds a
    // mispredict target that could not be applied because fetch was blocked.
    typedef enum logic {
        IDLE       = 1'b0,
        REDIR_PEND = 1'b1
    } hazard_state_t;

    // Winning hazard source this cycle, highest priority first.
    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_DC_MISS  = 3'd1,
        HZ_MISPRED  = 3'd2,
        HZ_LOAD_USE = 3'd3,
        HZ_IC_MISS  = 3'd4
    } hazard_cause_t;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating performance counters for stall cycles, flush events and redirects.
// Only instantiated when HAZARD_PERF_EN is defined.
module hazard_perf_counters
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_stall,
    input  logic             any_flush,
    input  logic             redirect_valid,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flush_events,
    output logic [CNT_W-1:0] perf_redirects
);

    // Each counter advances once per qualifying cycle and sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
            perf_redirects    <= '0;
        end else begin
            if (pc_stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (any_flush && (perf_flush_events != '1))
                perf_flush_events <= perf_flush_events + 1'b1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: combinational stall/flush controls for the
// pc, i2d, d2e, e2m and m2w registers plus the fetch-PC redirect.
// A two-state FSM holds a mispredict redirect that lands during an i-cache miss.
// Optional feature macro: HAZARD_PERF_EN adds saturating perf counter outputs.
//
// Handshake note: there is no valid/ready handshake here; every control is a
// level valid in the cycle it is asserted. redirect_valid means "load
// redirect_target into PC at the next edge"; redirect_target is 0 otherwise.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic              dc_miss,
    input  logic              dec_uses_rs,
    input  logic [REG_W-1:0]  dec_rs_addr,
    input  logic              dec_uses_rt,
    input  logic [REG_W-1:0]  dec_rt_addr,
    input  logic              ex_is_load,
    input  logic              ex_uses_rw,
    input  logic [REG_W-1:0]  ex_rw_addr,
    input  logic              br_valid,
    input  logic              br_mispredict,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pc_stall,
    output logic              i2d_stall,
    output logic              i2d_flush,
    output logic              d2e_stall,
    output logic              d2e_flush,
    output logic              e2m_stall,
    output logic              e2m_flush,
    output logic              m2w_stall,
    output logic              m2w_flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_target,
    output hazard_state_t     dbg_state,
    output hazard_cause_t     dbg_cause
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cycles,
    output logic [CNT_W-1:0]  perf_flush_events,
    output logic [CNT_W-1:0]  perf_redirects
`endif
);

    hazard_state_t     state, state_nxt;
    logic [ADDR_W-1:0] held_target, held_target_nxt;
    hazard_cause_t     cause;
    logic              load_use;
    logic              mp;

    // Hazard detection and priority selection; dc_miss freezes the branch in EX.
    always_comb begin
        load_use = ex_is_load && ex_uses_rw && (ex_rw_addr != '0) &&
                   ((dec_uses_rs && (dec_rs_addr == ex_rw_addr)) ||
                    (dec_uses_rt && (dec_rt_addr == ex_rw_addr)));
        mp = br_valid && br_mispredict && !dc_miss;
        if (dc_miss)       cause = HZ_DC_MISS;
        else if (mp)       cause = HZ_MISPRED;
        else if (load_use) cause = HZ_LOAD_USE;
        else if (ic_miss)  cause = HZ_IC_MISS;
        else               cause = HZ_NONE;
    end

    // State register and held redirect target; reset discards any pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            held_target <= '0;
        end else begin
            state       <= state_nxt;
            held_target <= held_target_nxt;
        end
    end

    // Next state: a mispredict blocked by ic_miss is parked; a pending one
    // is released once fetch and memory are both free (or replaced by a new one).
    always_comb begin
        state_nxt       = state;
        held_target_nxt = held_target;
        case (state)
            IDLE: begin
                if (mp && ic_miss) begin
                    state_nxt       = REDIR_PEND;
                    held_target_nxt = br_target;
                end
            end
            REDIR_PEND: begin
                if (mp && ic_miss) begin
                    held_target_nxt = br_target;
                end else if (mp || (!ic_miss && !dc_miss)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: priority cause first, then the pending-redirect overlay.
    always_comb begin
        pc_stall        = 1'b0;
        i2d_stall       = 1'b0;
        i2d_flush       = 1'b0;
        d2e_stall       = 1'b0;
        d2e_flush       = 1'b0;
        e2m_stall       = 1'b0;
        e2m_flush       = 1'b0;
        m2w_stall       = 1'b0;
        m2w_flush       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        if (rst_n) begin
            case (cause)
                HZ_DC_MISS: begin
                    pc_stall  = 1'b1;
                    i2d_stall = 1'b1;
                    d2e_stall = 1'b1;
                    e2m_stall = 1'b1;
                    m2w_flush = 1'b1;
                end
                HZ_MISPRED: begin
                    i2d_flush = 1'b1;
                    d2e_flush = 1'b1;
                    if (!ic_miss) begin
                        redirect_valid  = 1'b1;
                        redirect_target = br_target;
                    end else begin
                        pc_stall = 1'b1;
                    end
                end
                HZ_LOAD_USE: begin
                    pc_stall  = 1'b1;
                    i2d_stall = 1'b1;
                    d2e_flush = 1'b1;
                end
                HZ_IC_MISS: begin
                    pc_stall  = 1'b1;
                    i2d_flush = 1'b1;
                end
                default: ;
            endcase
            if (state == REDIR_PEND) begin
                pc_stall = 1'b1;
                if (!i2d_stall)
                    i2d_flush = 1'b1;
                if ((cause != HZ_MISPRED) && !ic_miss && !dc_miss) begin
                    redirect_valid  = 1'b1;
                    redirect_target = held_target;
                end
            end
        end
    end

    assign dbg_state = state;
    assign dbg_cause = rst_n ? cause : HZ_NONE;

`ifdef HAZARD_PERF_EN
    logic any_flush;
    assign any_flush = i2d_flush | d2e_flush | e2m_flush | m2w_flush;

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_stall          (pc_stall),
        .any_flush         (any_flush),
        .redirect_valid    (redirect_valid),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events),
        .perf_redirects    (perf_redirects)
    );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: each cycle the driver applies one
// input vector and queues the hand-derived control word; a negedge monitor
// pops and compares.
module tb_hazard_controller;
    import hazard_pkg::*;

    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 32;
    localparam int W      = 10 + ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              ic_miss, dc_miss;
    logic              dec_uses_rs, dec_uses_rt;
    logic [REG_W-1:0]  dec_rs_addr, dec_rt_addr;
    logic              ex_is_load, ex_uses_rw;
    logic [REG_W-1:0]  ex_rw_addr;
    logic              br_valid, br_mispredict;
    logic [ADDR_W-1:0] br_target;
    logic              pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush;
    logic              e2m_stall, e2m_flush, m2w_stall, m2w_flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    hazard_state_t     dbg_state;
    hazard_cause_t     dbg_cause;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0]  perf_stall_cycles, perf_flush_events, perf_redirects;
`endif

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;

    hazard_controller #(
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W)
`ifdef HAZARD_PERF_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ic_miss         (ic_miss),
        .dc_miss         (dc_miss),
        .dec_uses_rs     (dec_uses_rs),
        .dec_rs_addr     (dec_rs_addr),
        .dec_uses_rt     (dec_uses_rt),
        .dec_rt_addr     (dec_rt_addr),
        .ex_is_load      (ex_is_load),
        .ex_uses_rw      (ex_uses_rw),
        .ex_rw_addr      (ex_rw_addr),
        .br_valid        (br_valid),
        .br_mispredict   (br_mispredict),
        .br_target       (br_target),
        .pc_stall        (pc_stall),
        .i2d_stall       (i2d_stall),
        .i2d_flush       (i2d_flush),
        .d2e_stall       (d2e_stall),
        .d2e_flush       (d2e_flush),
        .e2m_stall       (e2m_stall),
        .e2m_flush       (e2m_flush),
        .m2w_stall       (m2w_stall),
        .m2w_flush       (m2w_flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dbg_state       (dbg_state),
        .dbg_cause       (dbg_cause)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events),
        .perf_redirects    (perf_redirects)
`endif
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control word; e2m_flush and m2w_stall are always 0.
    function automatic logic [W-1:0] ex(input logic pc_s, input logic i2d_s, input logic i2d_f,
                                        input logic d2e_s, input logic d2e_f, input logic e2m_s,
                                        input logic m2w_f, input logic rv, input logic [ADDR_W-1:0] tgt);
        return {pc_s, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, 1'b0, 1'b0, m2w_f, rv, tgt};
    endfunction

    localparam logic [ADDR_W-1:0] T1 = 32'h0040_0100;
    localparam logic [ADDR_W-1:0] T2 = 32'h0040_0200;
    localparam logic [ADDR_W-1:0] T3 = 32'h0040_0300;
    localparam logic [ADDR_W-1:0] T4 = 32'h0040_0400;

    logic [W-1:0] e_zero, e_lu, e_ic, e_dc, e_mp_ic;
    initial begin
        e_zero  = ex(0, 0, 0, 0, 0, 0, 0, 0, '0);
        e_lu    = ex(1, 1, 0, 0, 1, 0, 0, 0, '0);
        e_ic    = ex(1, 0, 1, 0, 0, 0, 0, 0, '0);
        e_dc    = ex(1, 1, 0, 1, 0, 1, 1, 0, '0);
        e_mp_ic = ex(1, 0, 1, 0, 1, 0, 0, 0, '0);
    end

    // Driver tasks
    task automatic clr();
        ic_miss = 0; dc_miss = 0;
        dec_uses_rs = 0; dec_rs_addr = '0; dec_uses_rt = 0; dec_rt_addr = '0;
        ex_is_load = 0; ex_uses_rw = 0; ex_rw_addr = '0;
        br_valid = 0; br_mispredict = 0; br_target = '0;
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rw, input logic [REG_W-1:0] rs);
        ex_is_load = 1; ex_uses_rw = 1; ex_rw_addr = rw;
        dec_uses_rs = 1; dec_rs_addr = rs;
    endtask

    task automatic set_mp(input logic [ADDR_W-1:0] t);
        br_valid = 1; br_mispredict = 1; br_target = t;
    endtask

    task automatic step(input string nm, input logic [W-1:0] exp_v);
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall,
                  e2m_flush, m2w_stall, m2w_flush, redirect_valid, redirect_target};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 0;
        clr();
        @(posedge clk);
        #1;

        // Reset: outputs forced low even with hazards on the inputs
        ic_miss = 1; set_mp(T1); set_lu(5'd3, 5'd3);
        step("reset_quiet", e_zero);
        dc_miss = 1;
        step("reset_quiet2", e_zero);
        rst_n = 1; clr();
        step("idle", e_zero);

        // Load-use via rs, then via rt, then non-hazard variants
        set_lu(5'd5, 5'd5);
        step("lu_rs", e_lu);
        clr();
        step("lu_rs_release", e_zero);
        ex_is_load = 1; ex_uses_rw = 1; ex_rw_addr = 5'd7;
        dec_uses_rt = 1; dec_rt_addr = 5'd7; dec_rs_addr = 5'd2; dec_uses_rs = 1;
        step("lu_rt", e_lu);
        dec_uses_rt = 0;
        dec_rs_addr = 5'd7; dec_uses_rs = 0;
        step("lu_unused_src", e_zero);
        clr(); set_lu(5'd0, 5'd0);
        step("lu_r0", e_zero);
        clr(); set_lu(5'd9, 5'd9); ex_is_load = 0;
        step("lu_not_load", e_zero);
        clr(); set_lu(5'd9, 5'd9); ex_uses_rw = 0;
        step("lu_no_write", e_zero);

        // Mispredict in IDLE
        clr(); set_mp(T1);
        step("mp_idle", ex(0, 0, 1, 0, 1, 0, 0, 1, T1));
        set_lu(5'd4, 5'd4);
        step("mp_over_lu", ex(0, 0, 1, 0, 1, 0, 0, 1, T1));
        clr(); br_valid = 1; br_target = T2;
        step("br_correct", e_zero);

        // i-cache miss alone and with load-use
        clr(); ic_miss = 1;
        step("ic_miss", e_ic);
        set_lu(5'd6, 5'd6);
        step("ic_plus_lu", e_lu);

        // Mispredict during a 3-cycle ic_miss
        clr(); ic_miss = 1; set_mp(T2);
        step("mp_ic_c1", e_mp_ic);
        clr(); ic_miss = 1;
        step("pend_c2", e_ic);
        step("pend_c3", e_ic);
        ic_miss = 0;
        step("pend_release", ex(1, 0, 1, 0, 0, 0, 0, 1, T2));
        step("after_release", e_zero);

        // dc_miss with the mispredict held 4 cycles, redirect on cycle 5
        clr(); dc_miss = 1; set_mp(T3);
        for (int i = 0; i < 4; i++) step("dc_hold_mp", e_dc);
        dc_miss = 0;
        step("dc_done_mp", ex(0, 0, 1, 0, 1, 0, 0, 1, T3));
        clr(); dc_miss = 1; ic_miss = 1; set_lu(5'd8, 5'd8);
        step("dc_over_all", e_dc);

        // REDIR_PEND held across a dc_miss and a load-use
        clr(); ic_miss = 1; set_mp(T4);
        step("pend_enter", e_mp_ic);
        clr(); dc_miss = 1;
        step("pend_dc", e_dc);
        dc_miss = 0; ic_miss = 1; set_lu(5'd10, 5'd10);
        step("pend_lu", e_lu);
        clr();
        step("pend_release2", ex(1, 0, 1, 0, 0, 0, 0, 1, T4));

        // New mispredict in REDIR_PEND replaces the held target
        clr(); ic_miss = 1; set_mp(T1);
        step("pend_enter_a", e_mp_ic);
        set_mp(T3);
        step("pend_overwrite", e_mp_ic);
        clr();
        step("pend_release_b", ex(1, 0, 1, 0, 0, 0, 0, 1, T3));

        // Async reset while in REDIR_PEND
        clr(); ic_miss = 1; set_mp(T2);
        step("pend_enter_r", e_mp_ic);
        clr(); ic_miss = 1; rst_n = 0;
        step("reset_in_pend", e_zero);
        rst_n = 1; ic_miss = 0;
        step("no_redirect_after_rst", e_zero);

`ifdef HAZARD_PERF_EN
        clr(); rst_n = 0;
        step("perf_reset", e_zero);
        rst_n = 1; set_lu(5'd5, 5'd5);
        for (int i = 0; i < 10; i++) step("perf_lu", e_lu);
        clr(); set_mp(T1);
        step("perf_mp", ex(0, 0, 1, 0, 1, 0, 0, 1, T1));
        clr();
        step("perf_idle", e_zero);
        n_cmp += 3;
        if (perf_stall_cycles !== 32'd10) begin
            n_fail++; $display("FAIL perf_stall_cycles: got %0d expected 10", perf_stall_cycles);
        end
        if (perf_flush_events !== 32'd11) begin
            n_fail++; $display("FAIL perf_flush_events: got %0d expected 11", perf_flush_events);
        end
        if (perf_redirects !== 32'd1) begin
            n_fail++; $display("FAIL perf_redirects: got %0d expected 1", perf_redirects);
        end
`endif

        // Drain, bounded
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Produces the stall and flush controls consumed by every pipeline register (pc, i2d, d2e, e2m, m2w), and the fetch-PC redirect.
- Hazard sources:
  - i-cache miss (IF)
  - load-use dependency (ID vs EX)
  - branch misprediction (resolved in EX)
  - d-cache miss (MEM)
- A small FSM holds a mispredict redirect that arrives while fetch is blocked by an i-cache miss.

Parameters:
- ADDR_W, 32, width of PC / redirect target
- REG_W, 5, register address width
- CNT_W, 32, width of perf counters (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ic_miss  in  1  i-cache cannot deliver the instruction this cycle
- dc_miss  in  1  d-cache access in MEM not complete this cycle
- dec_uses_rs  in  1  ID instruction reads rs
- dec_rs_addr  in  REG_W  ID rs address
- dec_uses_rt  in  1  ID instruction reads rt
- dec_rt_addr  in  REG_W  ID rt address
- ex_is_load  in  1  EX instruction is a memory read
- ex_uses_rw  in  1  EX instruction writes a register
- ex_rw_addr  in  REG_W  EX destination
- br_valid  in  1  EX holds a resolved branch
- br_mispredict  in  1  resolved branch was mispredicted
- br_target  in  ADDR_W  correct recovery target
- pc_stall  out  1  hold fetch PC
- i2d_stall, i2d_flush  out  1 each  IF/ID register control
- d2e_stall, d2e_flush  out  1 each  ID/EX register control
- e2m_stall, e2m_flush  out  1 each  EX/MEM register control
- m2w_stall, m2w_flush  out  1 each  MEM/WB register control
- redirect_valid  out  1  load br_target / held target into PC this cycle
- redirect_target  out  ADDR_W  redirect PC

Behaviour:
- Control outputs are combinational from inputs and state: same-cycle, zero latency.
- While rst_n is low, every output is 0. State resets to IDLE and the held target to 0.
- Flush only takes effect in a register that is not stalled, so a flush is never asserted together with that register's stall.
- load_use = ex_is_load & ex_uses_rw & ex_rw_addr != 0 & ((dec_uses_rs & rs==rw) | (dec_uses_rt & rt==rw)).
- mp = br_valid & br_mispredict & !dc_miss.
- Priority, highest first:
  1. dc_miss: pc, i2d, d2e, e2m stalled; m2w_flush=1; all other flushes 0; mispredict ignored (the branch stays frozen in EX and is re-evaluated).
  2. mp: i2d_flush=1, d2e_flush=1; load_use ignored.
     - IDLE & !ic_miss: redirect_valid=1, redirect_target=br_target.
     - IDLE & ic_miss: latch br_target, go to REDIR_PEND; pc_stall=1, no redirect this cycle.
  3. load_use: pc_stall=1, i2d_stall=1, d2e_flush=1.
  4. ic_miss: pc_stall=1; i2d_flush=1 unless i2d_stall.
- FSM:
  - IDLE: normal operation, as above.
  - REDIR_PEND:
    - pc_stall=1; i2d_flush=1 unless stalled by dc_miss/load_use.
    - When ic_miss=0 and dc_miss=0: redirect_valid=1, redirect_target=held target, return to IDLE.
    - A new mp in REDIR_PEND overwrites the held target. Not reachable in a legal pipeline; still defined.
- Reset mid-REDIR_PEND: held target discarded; return to IDLE.
- m2w_stall is always 0. e2m_flush is always 0; it is reserved and tied low.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cycles, perf_flush_events, perf_redirects, each CNT_W wide.
  - perf_stall_cycles increments every cycle pc_stall=1.
  - perf_flush_events increments per cycle with any flush asserted.
  - perf_redirects increments per redirect_valid.
  - Counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - typedef hazard_state_t {IDLE, REDIR_PEND}
  - typedef hazard_cause_t {HZ_NONE, HZ_DC_MISS, HZ_MISPRED, HZ_LOAD_USE, HZ_IC_MISS}, used for the priority mux and waveform debug
- One sub-module: hazard_perf_counters, instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: ex_is_load=1, ex_uses_rw=1, ex_rw_addr=5, dec_uses_rs=1, dec_rs_addr=5 -> pc_stall=1, i2d_stall=1, d2e_flush=1 for exactly that cycle; with ex_rw_addr=0 -> no stall.
- Mispredict idle: br_valid=1, br_mispredict=1, br_target=0x0040_0100 -> redirect_valid=1, target 0x0040_0100, i2d_flush=d2e_flush=1 same cycle.
- Mispredict during ic_miss: ic_miss=1 for 3 cycles with mp on the first -> no redirect for 3 cycles; redirect_valid=1 with the held target on the cycle ic_miss drops.
- dc_miss with concurrent mispredict: dc_miss=1 for 4 cycles and br inputs held -> pc/i2d/d2e/e2m stalled, m2w_flush=1, no redirect; redirect on cycle 5.
- Async reset asserted in REDIR_PEND -> all outputs 0 immediately; after release with ic_miss=0 -> no redirect.
- HAZARD_PERF_EN: 10 load-use cycles plus 1 mispredict -> perf_stall_cycles=10, perf_redirects=1, perf_flush_events=11.
